knn_query_sequencer: RTL and testbench

Control sequencer for the k-NN distance/sort datapath. Accepts one query (reference vector plus a stream of named training points) from an upstream source via valid/ready. Drives the datapath's load-reference, point-name/value and done inputs in the exact contiguous, cycle-aligned order the datapath requires. The datapath has no stall input and recirculates the reference vector every cycle, so this block enforces gap-free streaming and flags any violation.

---
 rtl/knn_query_sequencer_if.sv | 41 ++++
 rtl/knn_query_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_knn_query_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/knn_query_sequencer_if.sv
// -----------------------------------------------------------------------------
// knn_query_sequencer_if
// Upstream query bus feeding the k-NN query sequencer.
//   start/numPoints/kIn          : query launch and its parameters
//   refValid/refData/refReady    : reference-vector beat handshake
//   ptValid/ptName/ptData/ptReady: training-point beat handshake
// Modports:
//   master : the upstream query source
//   slave  : the sequencer
// -----------------------------------------------------------------------------
interface knn_query_sequencer_if #(
   parameter int dataWidth = 32,
   parameter int nameWidth = 32
) ();

   logic                 start;
   logic [31:0]          numPoints;
   logic [31:0]          kIn;
   logic                 refValid;
   logic [dataWidth-1:0] refData;
   logic                 refReady;
   logic                 ptValid;
   logic [nameWidth-1:0] ptName;
   logic [dataWidth-1:0] ptData;
   logic                 ptReady;

   modport master (
      output start, numPoints, kIn,
      output refValid, refData,
      output ptValid, ptName, ptData,
      input  refReady, ptReady
   );

   modport slave (
      input  start, numPoints, kIn,
      input  refValid, refData,
      input  ptValid, ptName, ptData,
      output refReady, ptReady
   );

endinterface

// File: rtl/knn_query_sequencer.sv
// -----------------------------------------------------------------------------
// knn_query_sequencer
// Control sequencer for the k-NN distance/sort datapath. Takes one query from
// the upstream bus (reference vector, then numPoints training points of
// numberOfDimensions beats each) and replays it to the datapath one cycle
// after acceptance. The datapath cannot stall, so any gap after the first
// reference beat aborts the query with a sticky protocolError.
// Ports:
//   clk, reset      : clock and asynchronous active-low reset
//   up (slave)      : upstream start / reference / point handshakes
//   loadRef         : datapath selects the external reference input
//   refDataOut      : reference value to datapath
//   dataNameOut     : point name to datapath (holds between beats)
//   dataValueOut    : point value to datapath (0 when no beat)
//   k               : neighbour count latched at start
//   done, queryDone : one-cycle end-of-query pulses
//   busy            : query in progress
//   protocolError   : sticky streaming violation flag
// -----------------------------------------------------------------------------
module knn_query_sequencer #(
   parameter int dataWidth          = 32,
   parameter int numberOfDimensions = 32,
   parameter int drainCycles        = 4,
   parameter int nameWidth          = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   knn_query_sequencer_if.slave       up,
   output logic                       loadRef,
   output logic [dataWidth-1:0]       refDataOut,
   output logic [nameWidth-1:0]       dataNameOut,
   output logic [dataWidth-1:0]       dataValueOut,
   output logic [31:0]                k,
   output logic                       done,
   output logic                       busy,
   output logic                       queryDone,
   output logic                       protocolError
);

   localparam int DimCntW   = $clog2(numberOfDimensions);
   localparam int DrainCntW = $clog2(drainCycles + 1);
   localparam logic [DimCntW-1:0]   DimLast   = DimCntW'(numberOfDimensions - 1);
   localparam logic [DrainCntW-1:0] DrainLast = DrainCntW'(drainCycles - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD_REF = 3'd1,
      STREAM   = 3'd2,
      DRAIN    = 3'd3,
      FINISH   = 3'd4
   } state_t;

   state_t                 state_q,         state_d;
   logic [DimCntW-1:0]     dimCnt_q,        dimCnt_d;
   logic [31:0]            ptCnt_q,         ptCnt_d;
   logic [DrainCntW-1:0]   drainCnt_q,      drainCnt_d;
   logic [31:0]            numPoints_q,     numPoints_d;
   logic [31:0]            k_q,             k_d;
   logic                   protocolError_q, protocolError_d;
   logic                   loadRef_q,       loadRef_d;
   logic [dataWidth-1:0]   refDataOut_q,    refDataOut_d;
   logic [nameWidth-1:0]   dataNameOut_q,   dataNameOut_d;
   logic [dataWidth-1:0]   dataValueOut_q,  dataValueOut_d;
   logic                   done_q,          done_d;
   logic                   busy_q,          busy_d;

   // Ready depends on state only, never on the valid inputs.
   assign up.refReady = (state_q == LOAD_REF);
   assign up.ptReady  = (state_q == STREAM);

   // Next-state, counter and datapath-output decode.
   always_comb begin
      state_d         = state_q;
      dimCnt_d        = dimCnt_q;
      ptCnt_d         = ptCnt_q;
      drainCnt_d      = drainCnt_q;
      numPoints_d     = numPoints_q;
      k_d             = k_q;
      protocolError_d = protocolError_q;
      loadRef_d       = 1'b0;
      refDataOut_d    = refDataOut_q;
      dataNameOut_d   = dataNameOut_q;
      dataValueOut_d  = {dataWidth{1'b0}};
      // done and busy are decoded from the current state and registered,
      // so they trail the state by one cycle.
      done_d          = (state_q == FINISH);
      busy_d          = (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (up.start) begin
               numPoints_d     = up.numPoints;
               k_d             = up.kIn;
               protocolError_d = 1'b0;
               dimCnt_d        = {DimCntW{1'b0}};
               ptCnt_d         = 32'd0;
               drainCnt_d      = {DrainCntW{1'b0}};
               state_d         = LOAD_REF;
            end else begin
               state_d = IDLE;
            end
         end

         LOAD_REF: begin
            if (up.refValid) begin
               loadRef_d    = 1'b1;
               refDataOut_d = up.refData;
               if (dimCnt_q == DimLast) begin
                  dimCnt_d = {DimCntW{1'b0}};
                  if (numPoints_q == 32'd0) begin
                     state_d = DRAIN;
                  end else begin
                     state_d = STREAM;
                  end
               end else begin
                  dimCnt_d = dimCnt_q + {{(DimCntW-1){1'b0}}, 1'b1};
               end
            end else if (dimCnt_q != {DimCntW{1'b0}}) begin
               // A gap after the first reference beat breaks the
               // datapath's recirculating reference.
               protocolError_d = 1'b1;
               state_d         = FINISH;
            end else begin
               // Still waiting for the first reference beat.
               state_d = LOAD_REF;
            end
         end

         STREAM: begin
            if (up.ptValid) begin
               dataNameOut_d  = up.ptName;
               dataValueOut_d = up.ptData;
               if (dimCnt_q == DimLast) begin
                  dimCnt_d = {DimCntW{1'b0}};
                  ptCnt_d  = ptCnt_q + 32'd1;
                  if ((ptCnt_q + 32'd1) == numPoints_q) begin
                     state_d = DRAIN;
                  end else begin
                     state_d = STREAM;
                  end
               end else begin
                  dimCnt_d = dimCnt_q + {{(DimCntW-1){1'b0}}, 1'b1};
               end
            end else begin
               // Aborted stream skips the drain: no further distances
               // are meaningful.
               protocolError_d = 1'b1;
               state_d         = FINISH;
            end
         end

         DRAIN: begin
            if (drainCnt_q == DrainLast) begin
               drainCnt_d = {DrainCntW{1'b0}};
               state_d    = FINISH;
            end else begin
               drainCnt_d = drainCnt_q + {{(DrainCntW-1){1'b0}}, 1'b1};
            end
         end

         FINISH: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= IDLE;
         dimCnt_q        <= {DimCntW{1'b0}};
         ptCnt_q         <= 32'd0;
         drainCnt_q      <= {DrainCntW{1'b0}};
         numPoints_q     <= 32'd0;
         k_q             <= 32'd0;
         protocolError_q <= 1'b0;
         loadRef_q       <= 1'b0;
         refDataOut_q    <= {dataWidth{1'b0}};
         dataNameOut_q   <= {nameWidth{1'b0}};
         dataValueOut_q  <= {dataWidth{1'b0}};
         done_q          <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         dimCnt_q        <= dimCnt_d;
         ptCnt_q         <= ptCnt_d;
         drainCnt_q      <= drainCnt_d;
         numPoints_q     <= numPoints_d;
         k_q             <= k_d;
         protocolError_q <= protocolError_d;
         loadRef_q       <= loadRef_d;
         refDataOut_q    <= refDataOut_d;
         dataNameOut_q   <= dataNameOut_d;
         dataValueOut_q  <= dataValueOut_d;
         done_q          <= done_d;
         busy_q          <= busy_d;
      end
   end

   assign loadRef       = loadRef_q;
   assign refDataOut    = refDataOut_q;
   assign dataNameOut   = dataNameOut_q;
   assign dataValueOut  = dataValueOut_q;
   assign k             = k_q;
   assign done          = done_q;
   assign queryDone     = done_q;
   assign busy          = busy_q;
   assign protocolError = protocolError_q;

endmodule

// File: tb/tb_knn_query_sequencer.sv
// -----------------------------------------------------------------------------
// tb_knn_query_sequencer
// Directed bench for knn_query_sequencer with 4 dimensions and 4 drain cycles.
// Expected latency from the start cycle to the done cycle is
// 1 + D + N*D + drainCycles + 1 (plus any wait before the first ref beat).
// -----------------------------------------------------------------------------
module tb_knn_query_sequencer;

   localparam int DW = 32;
   localparam int NW = 32;
   localparam int D  = 4;
   localparam int DR = 4;

   logic          clk;
   logic          reset;
   logic          loadRef;
   logic [DW-1:0] refDataOut;
   logic [NW-1:0] dataNameOut;
   logic [DW-1:0] dataValueOut;
   logic [31:0]   k;
   logic          done;
   logic          busy;
   logic          queryDone;
   logic          protocolError;

   int cyc      = 0;
   int n_checks = 0;
   int n_fail   = 0;

   knn_query_sequencer_if #(.dataWidth(DW), .nameWidth(NW)) up ();

   knn_query_sequencer #(
      .dataWidth(DW), .numberOfDimensions(D), .drainCycles(DR), .nameWidth(NW)
   ) dut (
      .clk(clk), .reset(reset), .up(up),
      .loadRef(loadRef), .refDataOut(refDataOut), .dataNameOut(dataNameOut),
      .dataValueOut(dataValueOut), .k(k), .done(done), .busy(busy),
      .queryDone(queryDone), .protocolError(protocolError)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete gap-free query; gap = idle cycles before the first ref
   // beat, poke = pulse start during STREAM and DRAIN.
   task automatic run_query(input int n, input logic [31:0] kv, input int gap, input bit poke);
      int t0;
      int waited;
      int extra;
      t0 = cyc;
      up.start = 1'b1; up.numPoints = n; up.kIn = kv;
      step();
      up.start = 1'b0; up.numPoints = 32'd99; up.kIn = 32'd77;
      check("k_latched", k, kv);
      check("err_cleared", protocolError, 1'b0);
      check("refReady_load", up.refReady, 1'b1);
      check("ptReady_load", up.ptReady, 1'b0);
      for (int g = 0; g < gap; g++) begin
         step();
         check("wait_no_err", protocolError, 1'b0);
         check("wait_no_load", loadRef, 1'b0);
      end
      for (int i = 0; i < D; i++) begin
         up.refValid = 1'b1; up.refData = 10 * (i + 1);
         step();
         check("loadRef_beat", loadRef, 1'b1);
         check("refDataOut", refDataOut, 10 * (i + 1));
         check("busy_run", busy, 1'b1);
      end
      up.refValid = 1'b0;
      for (int j = 0; j < n * D; j++) begin
         check("ptReady_stream", up.ptReady, 1'b1);
         up.ptValid = 1'b1; up.ptName = 7 + 2 * (j / D); up.ptData = 100 + j;
         if (poke && j == 5) begin
            up.start = 1'b1; up.numPoints = 32'd5; up.kIn = 32'd3;
         end
         step();
         up.start = 1'b0;
         check("dataNameOut", dataNameOut, 7 + 2 * (j / D));
         check("dataValueOut", dataValueOut, 100 + j);
         check("loadRef_stream", loadRef, 1'b0);
      end
      up.ptValid = 1'b0;
      waited = 0;
      while (done !== 1'b1 && waited < 20) begin
         check("ptReady_drain", up.ptReady, 1'b0);
         if (poke && waited == 0) up.start = 1'b1;
         step();
         up.start = 1'b0;
         waited++;
         if (done !== 1'b1) check("drain_value_zero", dataValueOut, 32'd0);
      end
      check("done_seen", done, 1'b1);
      check("latency", cyc - t0, 1 + D + n * D + DR + 1 + gap);
      check("queryDone", queryDone, 1'b1);
      check("busy_at_done", busy, 1'b1);
      check("no_error", protocolError, 1'b0);
      check("k_kept", k, kv);
      step();
      check("done_one_cycle", done, 1'b0);
      check("busy_falls", busy, 1'b0);
      extra = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         if (done === 1'b1) extra++;
      end
      check("single_done", extra, 0);
   endtask

   initial begin
      reset = 1'b0;
      up.start = 1'b0; up.numPoints = 32'd0; up.kIn = 32'd0;
      up.refValid = 1'b0; up.refData = 32'd0;
      up.ptValid = 1'b0; up.ptName = 32'd0; up.ptData = 32'd0;
      step();
      step();
      check("rst_loadRef", loadRef, 1'b0);
      check("rst_refDataOut", refDataOut, 32'd0);
      check("rst_k", k, 32'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_refReady", up.refReady, 1'b0);
      check("rst_ptReady", up.ptReady, 1'b0);
      reset = 1'b1;
      step();

      // Scenario 1: two points, k=1
      run_query(2, 32'd1, 0, 1'b0);

      // Scenario 2: no points, straight to drain
      run_query(0, 32'd2, 0, 1'b0);
      check("n0_name_hold", dataNameOut, 32'd9);

      // Scenario 5: start pulses during STREAM and DRAIN are ignored
      run_query(2, 32'd1, 0, 1'b1);

      // Scenario 3: ptValid dropped on the 6th point beat
      up.start = 1'b1; up.numPoints = 32'd2; up.kIn = 32'd5;
      step();
      up.start = 1'b0;
      for (int i = 0; i < D; i++) begin
         up.refValid = 1'b1; up.refData = 10 * (i + 1);
         step();
      end
      up.refValid = 1'b0;
      for (int j = 0; j < 5; j++) begin
         up.ptValid = 1'b1; up.ptName = 32'd7 + 2 * (j / D); up.ptData = 200 + j;
         step();
      end
      up.ptValid = 1'b0;
      step();
      check("err_set", protocolError, 1'b1);
      check("err_no_done_yet", done, 1'b0);
      check("err_value_zero", dataValueOut, 32'd0);
      check("err_ptReady", up.ptReady, 1'b0);
      step();
      check("err_done", done, 1'b1);
      check("err_queryDone", queryDone, 1'b1);
      check("err_busy", busy, 1'b1);
      step();
      check("err_done_low", done, 1'b0);
      check("err_idle", busy, 1'b0);
      check("err_sticky", protocolError, 1'b1);
      up.refValid = 1'b1; up.ptValid = 1'b1;
      step();
      check("idle_no_ref_accept", loadRef, 1'b0);
      check("idle_no_pt_accept", dataValueOut, 32'd0);
      check("err_still_sticky", protocolError, 1'b1);
      up.refValid = 1'b0; up.ptValid = 1'b0;

      // Scenario 6: 10-cycle wait before the first ref beat (also clears error)
      run_query(2, 32'd1, 10, 1'b0);

      // Scenario 4: reset during STREAM
      up.start = 1'b1; up.numPoints = 32'd2; up.kIn = 32'd4;
      step();
      up.start = 1'b0;
      for (int i = 0; i < D; i++) begin
         up.refValid = 1'b1; up.refData = 10 * (i + 1);
         step();
      end
      up.refValid = 1'b0;
      for (int j = 0; j < 3; j++) begin
         up.ptValid = 1'b1; up.ptName = 32'd7; up.ptData = 300 + j;
         step();
      end
      #2;
      reset = 1'b0;
      #1;
      check("arst_loadRef", loadRef, 1'b0);
      check("arst_refDataOut", refDataOut, 32'd0);
      check("arst_dataNameOut", dataNameOut, 32'd0);
      check("arst_dataValueOut", dataValueOut, 32'd0);
      check("arst_k", k, 32'd0);
      check("arst_busy", busy, 1'b0);
      check("arst_done", done, 1'b0);
      check("arst_queryDone", queryDone, 1'b0);
      check("arst_err", protocolError, 1'b0);
      check("arst_ptReady", up.ptReady, 1'b0);
      up.ptValid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         check("arst_no_done", done, 1'b0);
      end
      reset = 1'b1;
      step();
      run_query(2, 32'd1, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
